// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem read FSM and an in-order instruction buffer.
// Define FETCH_PERF_CNT_EN to add the stall_cnt/flush_cnt performance counters.
module fetch_unit #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               DEPTH    = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ready,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [WIDTH-1:0] if_instr,
   output logic [3:0]       if_op,
   output logic [WIDTH-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      flush_cnt
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] reqAddr;
   logic [WIDTH-1:0] tag;
   logic             drop;

   logic [WIDTH-1:0] memInstr [DEPTH];
   logic [WIDTH-1:0] memPc    [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] headInstr;
   logic [WIDTH-1:0] headPc;

   logic imemAccept;
   logic push;
   logic pop;
   logic hasRoom;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + 1'b1;
   endfunction

   assign imemAccept = (state == REQ) && imem_ready;
   // A redirect kills the response that would otherwise be pushed this cycle.
   assign push       = (state == WAIT) && imem_rvalid && !drop && !redirect;
   assign pop        = (count != '0) && if_ready;
   assign hasRoom    = count < CNT_W'(DEPTH);

   assign imem_req  = (state == REQ);
   assign imem_addr = reqAddr;
   assign if_valid  = (count != '0);
   assign if_instr  = headInstr;
   assign if_op     = headInstr[WIDTH-1:WIDTH-4];
   assign if_pc     = headPc;

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_pc;
      end else if (imemAccept && !drop) begin
         pc <= pc + 1'b1;
      end
   end

   // drop marks the single outstanding (or about-to-be-accepted) response as stale.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         reqAddr <= RESET_PC;
         tag     <= '0;
         drop    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (redirect || hasRoom) begin
                  state   <= REQ;
                  reqAddr <= redirect ? redirect_pc : pc;
               end
            end
            REQ: begin
               if (redirect) drop <= 1'b1;
               if (imem_ready) begin
                  state <= WAIT;
                  tag   <= reqAddr;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  state <= IDLE;
                  drop  <= 1'b0;
               end else if (redirect) begin
                  drop <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: buffer storage is data-only and deliberately not reset; count and pointers qualify it.
   always_ff @(posedge clk) begin
      if (push) begin
         memInstr[wrPtr] <= imem_rdata;
         memPc[wrPtr]    <= tag;
      end
   end

   // headInstr/headPc mirror the FIFO head and keep their last value once the buffer drains.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count     <= '0;
         rdPtr     <= '0;
         wrPtr     <= '0;
         headInstr <= '0;
         headPc    <= '0;
      end else if (redirect) begin
         count <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
      end else begin
         if (push) wrPtr <= nextPtr(wrPtr);
         if (pop)  rdPtr <= nextPtr(rdPtr);

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (pop) begin
            if (count > CNT_W'(1)) begin
               headInstr <= memInstr[nextPtr(rdPtr)];
               headPc    <= memPc[nextPtr(rdPtr)];
            end else if (push) begin
               headInstr <= imem_rdata;
               headPc    <= tag;
            end
         end else if ((count == '0) && push) begin
            headInstr <= imem_rdata;
            headPc    <= tag;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (if_valid && !if_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (redirect && (flush_cnt != '1))              flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized phase checked against
// an in-order instruction-stream model (expected next PC) and a latency-randomized memory model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req, imem_ready, imem_rvalid;
   logic [15:0] imem_addr, imem_rdata;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        if_valid, if_ready;
   logic [15:0] if_instr, if_pc;
   logic [3:0]  if_op;

   logic        imem_req2, imem_ready2, imem_rvalid2;
   logic [15:0] imem_addr2, imem_rdata2;
   logic        if_valid2, if_ready2;
   logic [15:0] if_instr2, if_pc2;
   logic [3:0]  if_op2;

   always #5 clk = ~clk;

   fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_op(if_op), .if_pc(if_pc)
   );

   fetch_unit #(.WIDTH(16), .RESET_PC(16'hFFFF), .DEPTH(2)) dutWrap (
      .clk(clk), .reset_n(reset_n),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready2),
      .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
      .redirect(1'b0), .redirect_pc(16'h0000),
      .if_valid(if_valid2), .if_ready(if_ready2), .if_instr(if_instr2), .if_op(if_op2), .if_pc(if_pc2)
   );

   int          checks = 0;
   int          failures = 0;
   logic [15:0] memArr [256];
   logic [15:0] expPc;
   int          popCnt = 0;
   int          memLat = 1;
   bit          randMode = 1'b0;
   bit          pendValid = 1'b0;
   logic [15:0] pendAddr;
   int          pendWait;
   logic [15:0] addrLog2 [$];
   logic [15:0] pcLog2 [$];
   logic [15:0] instrLog2 [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: score pops, advance the memory models, check cycle-level properties.
   task automatic tick();
      logic        acc, pop, redir, stall, reqHold, acc2;
      logic [15:0] accAddr, accAddr2, prevPc, prevInstr, prevAddr;
      acc       = imem_req && imem_ready;
      accAddr   = imem_addr;
      pop       = if_valid && if_ready;
      redir     = redirect;
      stall     = if_valid && !if_ready && !redir;
      reqHold   = imem_req && !imem_ready;
      prevPc    = if_pc;
      prevInstr = if_instr;
      prevAddr  = imem_addr;
      acc2      = imem_req2 && imem_ready2;
      accAddr2  = imem_addr2;
      if (acc2) addrLog2.push_back(imem_addr2);
      if (if_valid2 && if_ready2) begin
         pcLog2.push_back(if_pc2);
         instrLog2.push_back(if_instr2);
      end
      if (pop) begin
         chk("pop_pc", if_pc, expPc);
         chk("pop_instr", if_instr, memArr[expPc[7:0]]);
         chk("pop_op", if_op, memArr[expPc[7:0]][15:12]);
         popCnt++;
      end
      if (redir) expPc = redirect_pc;
      else if (pop) expPc = expPc + 16'd1;

      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (acc) begin
         pendValid = 1'b1;
         pendAddr  = accAddr;
         pendWait  = randMode ? int'($urandom_range(1, 3)) : memLat;
      end
      if (pendValid) begin
         pendWait--;
         if (pendWait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memArr[pendAddr[7:0]];
            pendValid   = 1'b0;
         end
      end
      if (!imem_rvalid) imem_rdata = 16'($urandom);
      imem_rvalid2 = acc2;
      imem_rdata2  = memArr[accAddr2[7:0]];

      if (pendValid || imem_rvalid) chk("one_outstanding", imem_req, 0);
      if (reqHold) begin
         chk("req_hold", imem_req, 1);
         chk("addr_hold", imem_addr, prevAddr);
      end
      if (redir) chk("flush", if_valid, 0);
      if (stall) begin
         chk("stall_valid", if_valid, 1);
         chk("stall_pc", if_pc, prevPc);
         chk("stall_instr", if_instr, prevInstr);
      end

      redirect = 1'b0;
      if (randMode) begin
         imem_ready = ($urandom_range(0, 3) != 0);
         if_ready   = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 15) == 0) begin
            redirect    = 1'b1;
            redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) memArr[i] = 16'($urandom);
      memArr[0] = 16'h1234;
      memArr[1] = 16'h8ABC;

      reset_n = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; if_ready = 1'b1;
      imem_ready2 = 1'b1; imem_rvalid2 = 1'b0; imem_rdata2 = '0; if_ready2 = 1'b1;
      expPc = 16'h0000;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_valid", if_valid, 0);
      chk("rst_instr", if_instr, 16'h0000);
      chk("rst_op", if_op, 4'h0);
      chk("rst_pc", if_pc, 16'h0000);
      chk("wrap_rst_addr", imem_addr2, 16'hFFFF);
      chk("wrap_rst_pc", if_pc2, 16'h0000);

      // Release: request at RESET_PC on the first edge; decode stalled to fill the buffer
      reset_n  = 1'b1;
      if_ready = 1'b0;
      tick();
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, 16'h0000);

      repeat (12) tick();
      chk("full_valid", if_valid, 1);
      chk("full_no_req", imem_req, 0);
      chk("full_head_pc", if_pc, 16'h0000);
      chk("full_head_instr", if_instr, 16'h1234);
      chk("full_head_op", if_op, 4'h1);

      // Drain in order; the next fetch uses a 2-cycle memory
      memLat   = 2;
      if_ready = 1'b1;
      tick();
      chk("drain_pc1", if_pc, 16'h0001);
      chk("drain_instr1", if_instr, 16'h8ABC);
      chk("drain_op1", if_op, 4'h8);

      // Redirect while waiting on addr 2
      n = 0;
      while (!(imem_req && imem_ready && imem_addr == 16'h0002) && n < 50) begin tick(); n++; end
      chk("t4_req_addr2", imem_addr, 16'h0002);
      tick();
      redirect    = 1'b1;
      redirect_pc = 16'h0040;
      tick();
      n = 0;
      while (!imem_req && n < 50) begin tick(); n++; end
      chk("t4_next_addr", imem_addr, 16'h0040);
      n = 0;
      while (!if_valid && n < 50) begin tick(); n++; end
      chk("t4_first_pc", if_pc, 16'h0040);
      chk("t4_first_instr", if_instr, memArr[8'h40]);

      // Reset during WAIT with a late response
      memLat = 3;
      n = 0;
      while (!pendValid && n < 50) begin tick(); n++; end
      chk("t6_inflight", pendValid, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_req", imem_req, 0);
      chk("t6_rst_valid", if_valid, 0);
      chk("t6_rst_addr", imem_addr, 16'h0000);
      chk("t6_rst_pc", if_pc, 16'h0000);
      imem_rvalid = 1'b1; imem_rdata = 16'hDEAD; imem_ready = 1'b0; imem_rvalid2 = 1'b0;
      pendValid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("t6_late_valid", if_valid, 0);
      chk("t6_restart_req", imem_req, 1);
      chk("t6_restart_addr", imem_addr, 16'h0000);
      imem_rvalid = 1'b0;
      imem_ready  = 1'b1;
      memLat      = 1;
      expPc       = 16'h0000;
      n = 0;
      while (!if_valid && n < 50) begin tick(); n++; end
      chk("t6_first_pc", if_pc, 16'h0000);
      chk("t6_first_instr", if_instr, 16'h1234);

      // Randomized traffic against the stream model
      randMode = 1'b1;
      n = popCnt;
      repeat (3000) tick();
      chk("rand_progress", (popCnt - n) > 100, 1);

      // RESET_PC=FFFF instance: address and PC wrap
      chk("wrap_addr_count", addrLog2.size() >= 2, 1);
      if (addrLog2.size() >= 2) begin
         chk("wrap_addr0", addrLog2[0], 16'hFFFF);
         chk("wrap_addr1", addrLog2[1], 16'h0000);
      end
      chk("wrap_pc_count", pcLog2.size() >= 2, 1);
      if (pcLog2.size() >= 2) begin
         chk("wrap_pc0", pcLog2[0], 16'hFFFF);
         chk("wrap_pc1", pcLog2[1], 16'h0000);
         chk("wrap_instr0", instrLog2[0], memArr[8'hFF]);
         chk("wrap_instr1", instrLog2[1], 16'h1234);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
